// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state
// encoding, fault codes and the default response timeout.
package instruction_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_TIMEOUT  = 2'b10
  } fault_code_e;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts cycles spent waiting for a memory response; expired flags the
// TIMEOUT-th consecutive enabled cycle and stays asserted after that.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count_q;
  logic         at_limit;

  // Saturates one below TIMEOUT so a redirect that defers the fault cannot wrap it.
  assign at_limit = (count_q == W'(TIMEOUT - 1));
  assign expired  = enable && at_limit;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !at_limit) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch: reads imem at pc, holds the word for
// decode, drives the PC enable and flags misaligned PCs and memory timeouts.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pc,
  output logic         pc_en,
  input  logic         redirect,
  input  logic         stall,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  input  logic         mem_ready,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata,
  output logic [31:0]  instr,
  output logic [N-1:0] instr_pc,
  output logic         instr_valid,
  output logic         fetch_fault,
  output logic [1:0]   fault_code
);

  fetch_state_e state_q, state_d;
  fault_code_e  code_q, code_d;
  logic         drop_q, drop_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [N-1:0] ipc_q, ipc_d;

  logic tmo_clear, tmo_en, tmo_expired;
  logic aligned;

  assign aligned = (pc[1:0] == 2'b00);

  fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    drop_d    = drop_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    pc_en     = 1'b0;
    mem_req   = 1'b0;
    tmo_clear = 1'b0;
    tmo_en    = 1'b0;

    // Decode consumes the slot on any cycle it is not stalling.
    if (valid_q && !stall) valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;

      ST_REQ: begin
        if (redirect) begin
          pc_en   = 1'b1;
          valid_d = 1'b0;
          mem_req = aligned;
          if (aligned && mem_ready) begin
            tmo_clear = 1'b1;
            drop_d    = 1'b1;
            state_d   = ST_WAIT;
          end
        end else if (valid_q && stall) begin
          state_d = ST_HOLD;
        end else if (!aligned) begin
          code_d  = FAULT_MISALIGN;
          state_d = ST_FAULT;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ipc_d     = pc;
            tmo_clear = 1'b1;
            drop_d    = 1'b0;
            state_d   = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        tmo_en = 1'b1;
        if (redirect) begin
          pc_en   = 1'b1;
          valid_d = 1'b0;
          if (mem_rvalid) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (mem_rvalid) begin
          if (!drop_q) begin
            instr_d = mem_rdata;
            valid_d = 1'b1;
            pc_en   = 1'b1;
          end
          drop_d  = 1'b0;
          state_d = ST_REQ;
        end else if (tmo_expired) begin
          drop_d  = 1'b0;
          code_d  = FAULT_TIMEOUT;
          state_d = ST_FAULT;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_en   = 1'b1;
          valid_d = 1'b0;
          state_d = ST_REQ;
        end else if (!stall) begin
          state_d = ST_REQ;
        end
      end

      ST_FAULT: begin
        if (redirect) begin
          pc_en   = 1'b1;
          valid_d = 1'b0;
          code_d  = FAULT_NONE;
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the instruction slot is reset along with the control state because
  // decode-facing outputs must read zero while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= FAULT_NONE;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  assign mem_addr    = mem_req ? pc : '0;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign fault_code  = code_q;
  assign fetch_fault = (code_q != FAULT_NONE);

endmodule
